// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract unit: FSM encodings
// and format-derived helpers parametrised by exponent/fraction widths.
package fp_pkg;

   typedef logic [3:0] fp_state_t;

   localparam fp_state_t ST_GET_A   = 4'd0;
   localparam fp_state_t ST_GET_B   = 4'd1;
   localparam fp_state_t ST_UNPACK  = 4'd2;
   localparam fp_state_t ST_SPECIAL = 4'd3;
   localparam fp_state_t ST_ALIGN   = 4'd4;
   localparam fp_state_t ST_ADD     = 4'd5;
   localparam fp_state_t ST_NORM    = 4'd6;
   localparam fp_state_t ST_ROUND   = 4'd7;
   localparam fp_state_t ST_PACK    = 4'd8;
   localparam fp_state_t ST_PUT_Z   = 4'd9;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int fp_width(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   // Canonical quiet NaN in the low bits of a 64-bit word; callers slice to width.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
      v[man_w - 1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational right shift of a significand with guard, round and sticky
// bits appended; large shifts collapse the whole significand into sticky.
module fp_align_shifter
   import fp_pkg::*;
#(
   parameter int MAN_W = 23,
   parameter int SH_W  = 9
) (
   input  logic [MAN_W:0]   sig,
   input  logic [SH_W-1:0]  shamt,
   output logic [MAN_W+3:0] sig_grs
);

   localparam int FW = 2 * MAN_W + 4;

   logic [FW-1:0] full;

   always_comb begin
      full = {sig, {(MAN_W + 3){1'b0}}} >> shamt;
      if (shamt >= SH_W'(MAN_W + 3))
         sig_grs = {{(MAN_W + 3){1'b0}}, |sig};
      else
         sig_grs = {full[FW-1 -: MAN_W + 3], |full[MAN_W:0]};
   end

endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754-style adder/subtractor with stb/ack handshakes on
// both operands and the result; one operation in flight at a time.
//
// state   | meaning
// GET_A   | wait for operand A (ack raised one cycle after reset)
// GET_B   | wait for operand B and op
// UNPACK  | split fields, apply op to B sign, subnormal handling
// SPECIAL | NaN/inf/zero short-cut straight to PUT_Z
// ALIGN   | shift smaller-exponent significand right
// ADD     | magnitude add/subtract
// NORM    | carry right shift, or left shift per cycle until normal
// ROUND   | round to nearest, ties to even
// PACK    | form result word, overflow to inf
// PUT_Z   | present result until consumer acks
module fp_addsub
   import fp_pkg::*;
#(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = fp_width(EXP_W, MAN_W)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] input_a,
   input  logic         input_a_stb,
   output logic         input_a_ack,
   input  logic [W-1:0] input_b,
   input  logic         input_op,
   input  logic         input_b_stb,
   output logic         input_b_ack,
   output logic [W-1:0] output_z,
   output logic         output_z_stb,
   input  logic         output_z_ack
);

   localparam int EW = EXP_W + 1;
   localparam int SW = MAN_W + 4;
   localparam logic [EW-1:0] E_ONE  = EW'(1);
   localparam logic [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic [63:0]   QNAN64 = fp_qnan(EXP_W, MAN_W);
   localparam logic [W-1:0]  QNAN   = QNAN64[W-1:0];

   fp_state_t        state;
   logic [W-1:0]     a_reg, b_reg;
   logic             op_reg;
   logic             a_s, b_s, z_s;
   logic [EW-1:0]    a_e, b_e, z_e;
   logic [MAN_W:0]   a_m, b_m, z_m;
   logic [SW-1:0]    a_al, b_al;
   logic [SW:0]      sum;

   logic [EXP_W-1:0] a_exp_f, b_exp_f;
   logic [MAN_W-1:0] a_frac, b_frac;
   logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic             spec_hit;
   logic [W-1:0]     spec_z, pack_z;
   logic             a_big;
   logic [MAN_W:0]   sh_in;
   logic [EW-1:0]    sh_amt;
   logic [SW-1:0]    sh_out;
   logic             round_up;
   logic [MAN_W+1:0] rnd_m;

   assign a_exp_f = a_reg[W-2 -: EXP_W];
   assign b_exp_f = b_reg[W-2 -: EXP_W];
   assign a_frac  = a_reg[MAN_W-1:0];
   assign b_frac  = b_reg[MAN_W-1:0];
   assign a_nan   = (&a_exp_f) && (|a_frac);
   assign b_nan   = (&b_exp_f) && (|b_frac);
   assign a_inf   = (&a_exp_f) && !(|a_frac);
   assign b_inf   = (&b_exp_f) && !(|b_frac);
   assign a_zero  = !(|a_exp_f) && !(|a_frac);
   assign b_zero  = !(|b_exp_f) && !(|b_frac);

   always_comb begin
      spec_hit = 1'b1;
      spec_z   = QNAN;
      if (a_nan || b_nan)
         spec_z = QNAN;
      else if (a_inf && b_inf && (a_s != b_s))
         spec_z = QNAN;
      else if (a_inf)
         spec_z = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (b_inf)
         spec_z = {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (a_zero && b_zero)
         spec_z = {a_s & b_s, {(W - 1){1'b0}}};
      else
         spec_hit = 1'b0;
   end

   assign a_big  = (a_e >= b_e);
   assign sh_in  = a_big ? b_m : a_m;
   assign sh_amt = a_big ? (a_e - b_e) : (b_e - a_e);

   fp_align_shifter #(
      .MAN_W (MAN_W),
      .SH_W  (EW)
   ) u_align (
      .sig     (sh_in),
      .shamt   (sh_amt),
      .sig_grs (sh_out)
   );

   // sum layout: [SW] carry, [SW-1] hidden, fraction, then guard/round/sticky
   assign round_up = sum[2] & (sum[1] | sum[0] | sum[3]);
   assign rnd_m    = {1'b0, sum[MAN_W+3:3]} + (MAN_W + 2)'(round_up);

   always_comb begin
      if (z_e >= E_MAX)
         pack_z = {z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (!z_m[MAN_W])
         pack_z = {z_s, {EXP_W{1'b0}}, z_m[MAN_W-1:0]};
      else
         pack_z = {z_s, z_e[EXP_W-1:0], z_m[MAN_W-1:0]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_GET_A;
         input_a_ack  <= 1'b0;
         input_b_ack  <= 1'b0;
         output_z_stb <= 1'b0;
         output_z     <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         op_reg       <= 1'b0;
         a_s          <= 1'b0;
         b_s          <= 1'b0;
         z_s          <= 1'b0;
         a_e          <= '0;
         b_e          <= '0;
         z_e          <= '0;
         a_m          <= '0;
         b_m          <= '0;
         z_m          <= '0;
         a_al         <= '0;
         b_al         <= '0;
         sum          <= '0;
      end else begin
         case (state)
            ST_GET_A: begin
               if (!input_a_ack) begin
                  input_a_ack <= 1'b1;
               end else if (input_a_stb) begin
                  a_reg       <= input_a;
                  input_a_ack <= 1'b0;
                  input_b_ack <= 1'b1;
                  state       <= ST_GET_B;
               end
            end
            ST_GET_B: begin
               if (input_b_stb) begin
                  b_reg       <= input_b;
                  op_reg      <= input_op;
                  input_b_ack <= 1'b0;
                  state       <= ST_UNPACK;
               end
            end
            ST_UNPACK: begin
               a_s   <= a_reg[W-1];
               b_s   <= b_reg[W-1] ^ op_reg;
               a_e   <= (a_exp_f == '0) ? E_ONE : {1'b0, a_exp_f};
               b_e   <= (b_exp_f == '0) ? E_ONE : {1'b0, b_exp_f};
               a_m   <= {|a_exp_f, a_frac};
               b_m   <= {|b_exp_f, b_frac};
               state <= ST_SPECIAL;
            end
            ST_SPECIAL: begin
               if (spec_hit) begin
                  output_z     <= spec_z;
                  output_z_stb <= 1'b1;
                  state        <= ST_PUT_Z;
               end else begin
                  state <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               if (a_big) begin
                  a_al <= {a_m, 3'b000};
                  b_al <= sh_out;
                  z_e  <= a_e;
               end else begin
                  a_al <= sh_out;
                  b_al <= {b_m, 3'b000};
                  z_e  <= b_e;
               end
               state <= ST_ADD;
            end
            ST_ADD: begin
               if (a_s == b_s) begin
                  sum <= {1'b0, a_al} + {1'b0, b_al};
                  z_s <= a_s;
               end else if (a_al >= b_al) begin
                  sum <= {1'b0, a_al} - {1'b0, b_al};
                  z_s <= (a_al == b_al) ? 1'b0 : a_s;
               end else begin
                  sum <= {1'b0, b_al} - {1'b0, a_al};
                  z_s <= b_s;
               end
               state <= ST_NORM;
            end
            ST_NORM: begin
               if (sum[SW]) begin
                  sum   <= {1'b0, sum[SW:2], sum[1] | sum[0]};
                  z_e   <= z_e + E_ONE;
                  state <= ST_ROUND;
               end else if (!sum[SW-1] && (z_e > E_ONE)) begin
                  sum <= sum << 1;
                  z_e <= z_e - E_ONE;
               end else begin
                  state <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               if (rnd_m[MAN_W+1]) begin
                  z_m <= rnd_m[MAN_W+1:1];
                  z_e <= z_e + E_ONE;
               end else begin
                  z_m <= rnd_m[MAN_W:0];
               end
               state <= ST_PACK;
            end
            ST_PACK: begin
               output_z     <= pack_z;
               output_z_stb <= 1'b1;
               state        <= ST_PUT_Z;
            end
            ST_PUT_Z: begin
               if (output_z_ack) begin
                  output_z_stb <= 1'b0;
                  input_a_ack  <= 1'b1;
                  state        <= ST_GET_A;
               end
            end
            default: state <= ST_GET_A;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub.sv
// Directed bench for fp_addsub: single and half-precision instances,
// hand-computed results, latency, handshake and reset behaviour.
module tb_fp_addsub;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] input_a = '0, input_b = '0, output_z;
   logic        input_a_stb = 1'b0, input_b_stb = 1'b0, input_op = 1'b0;
   logic        output_z_ack = 1'b0;
   logic        input_a_ack, input_b_ack, output_z_stb;

   logic [15:0] h_a = '0, h_b = '0, h_z;
   logic        h_a_stb = 1'b0, h_b_stb = 1'b0, h_op = 1'b0, h_z_ack = 1'b0;
   logic        h_a_ack, h_b_ack, h_z_stb;

   int checks   = 0;
   int failures = 0;

   fp_addsub dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .input_b      (input_b),
      .input_op     (input_op),
      .input_b_stb  (input_b_stb),
      .input_b_ack  (input_b_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   fp_addsub #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk          (clk),
      .rst          (rst),
      .input_a      (h_a),
      .input_a_stb  (h_a_stb),
      .input_a_ack  (h_a_ack),
      .input_b      (h_b),
      .input_op     (h_op),
      .input_b_stb  (h_b_stb),
      .input_b_ack  (h_b_ack),
      .output_z     (h_z),
      .output_z_stb (h_z_stb),
      .output_z_ack (h_z_ack)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_a(input logic [31:0] v);
      int n;
      n = 0;
      input_a = v;
      input_a_stb = 1'b1;
      while (input_a_ack !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("a_ack_timeout", {63'b0, input_a_ack}, 64'd1);
      @(posedge clk);
      #1;
      input_a_stb = 1'b0;
      chk("a_ack_drop", {63'b0, input_a_ack}, 64'd0);
   endtask

   task automatic send_b(input logic [31:0] v, input logic op);
      int n;
      n = 0;
      input_b = v;
      input_op = op;
      input_b_stb = 1'b1;
      while (input_b_ack !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("b_ack_timeout", {63'b0, input_b_ack}, 64'd1);
      @(posedge clk);
      #1;
      input_b_stb = 1'b0;
      chk("b_ack_drop", {63'b0, input_b_ack}, 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] exp_z, input int exp_lat,
                         input int hold);
      int n;
      send_a(a);
      send_b(b, op);
      n = 0;
      while (output_z_stb !== 1'b1 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk($sformatf("%s_lat", tag), 64'(n), 64'(exp_lat));
      chk($sformatf("%s_z", tag), {32'b0, output_z}, {32'b0, exp_z});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s_hold_stb", tag), {63'b0, output_z_stb}, 64'd1);
         chk($sformatf("%s_hold_z", tag), {32'b0, output_z}, {32'b0, exp_z});
      end
      output_z_ack = 1'b1;
      @(posedge clk);
      #1;
      output_z_ack = 1'b0;
      chk($sformatf("%s_post_xfer", tag), {62'b0, output_z_stb, input_a_ack}, 64'd1);
   endtask

   initial begin
      int  n;
      logic seen;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {input_a_ack, input_b_ack, output_z_stb, output_z}, 64'd0);
      chk("reset_outputs_h", {h_a_ack, h_b_ack, h_z_stb, h_z}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("a_ack_first_edge", {63'b0, input_a_ack}, 64'd1);

      // B offered before A must not be acknowledged
      input_b = 32'h40000000;
      input_b_stb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("b_held_off", {63'b0, input_b_ack}, 64'd0);
      end
      input_b_stb = 1'b0;

      run_op("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 7, 5);
      run_op("sub_k2",       32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 9, 0);
      run_op("sub_zero",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 133, 0);
      run_op("inf_m_inf",    32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2, 0);
      run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 7, 0);
      run_op("subnormal",    32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 7, 0);
      run_op("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 7, 0);
      run_op("tie_up",       32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 7, 0);
      run_op("nan_in",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2, 0);
      run_op("neg_zeros",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 2, 0);
      run_op("pz_minus_pz",  32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 2, 0);
      run_op("neg_inf",      32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 2, 0);
      run_op("three_m_two",  32'h40400000, 32'h40000000, 1'b1, 32'h3F800000, 8, 0);
      run_op("one_m_two",    32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 8, 0);

      // half precision 1.0 + 1.0
      h_a = 16'h3C00;
      h_a_stb = 1'b1;
      n = 0;
      while (h_a_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1;
      h_a_stb = 1'b0;
      h_b = 16'h3C00;
      h_b_stb = 1'b1;
      n = 0;
      while (h_b_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1;
      h_b_stb = 1'b0;
      n = 0;
      while (h_z_stb !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk("half_lat", 64'(n), 64'd7);
      chk("half_z", {48'b0, h_z}, 64'h4000);
      h_z_ack = 1'b1;
      @(posedge clk);
      #1;
      h_z_ack = 1'b0;

      // reset asserted while the operation sits in ALIGN
      send_a(32'h3F800000);
      send_b(32'h40000000, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_mid_outputs", {input_a_ack, input_b_ack, output_z_stb, output_z}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_a_ack", {63'b0, input_a_ack}, 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         seen = seen | output_z_stb;
      end
      chk("rst_mid_no_z", {63'b0, seen}, 64'd0);
      run_op("after_rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 7, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
